// File: rtl/uart_seq_pkg.sv
// Shared constants for the UART/ALU sequencer: FSM state codes, default widths, ALU opcodes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_seq_pkg;

  localparam int NB_STATE    = 3;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [NB_STATE-1:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // Opcodes understood by the ALU; the sequencer forwards them untouched.
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_seq_timeout.sv
// Clearable up-counter flagging when the inter-byte idle window has been used up.
// Latency: o_terminal is a compare on the registered count, valid the cycle the count lands.
// Backpressure: none; clear has priority over enable, counting stops only via clear.
module uart_seq_timeout #(
  parameter int NB_TIMEOUT    = 20,
  parameter int TIMEOUT_TICKS = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [NB_TIMEOUT-1:0] LAST_TICK = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

  logic [NB_TIMEOUT-1:0] count;

  // Count idle cycles; any clear request restarts the window.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + NB_TIMEOUT'(1);
    end
  end

  assign o_terminal = (count == LAST_TICK);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects A, B, opcode bytes from uart_rx, lets the ALU settle one cycle, then hands the result to uart_tx.
// Latency: opcode strobe at edge T -> o_tx_start/o_tx_data valid during T+1..T+2.
// Backpressure: bytes arriving in EXEC/SEND/WAIT_TX are dropped; waits for i_tx_done before the next transaction.
// Optional inter-byte timeout enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_alu_sequencer
  import uart_seq_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OP         = NB_OP_DEF,
  parameter int NB_TIMEOUT    = 20,
  parameter int TIMEOUT_TICKS = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err_timeout
);

  state_t state;
  logic   timeout_hit;

`ifdef UART_SEQ_TIMEOUT_EN
  logic waiting_byte;
  logic cnt_clear;
  logic cnt_terminal;

  // Only the gaps inside a transaction are timed; the first byte may take forever.
  assign waiting_byte = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  // Restart on any byte, outside the timed states, and right after firing.
  assign cnt_clear    = i_rx_done || !waiting_byte || cnt_terminal;
  // A byte arriving on the terminal cycle wins over the timeout.
  assign timeout_hit  = waiting_byte && cnt_terminal && !i_rx_done;

  uart_seq_timeout #(
    .NB_TIMEOUT   (NB_TIMEOUT),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (cnt_clear),
    .i_enable  (waiting_byte),
    .o_terminal(cnt_terminal)
  );

  // One-cycle error pulse coincident with the abort back to WAIT_A.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_err_timeout <= 1'b0;
    end else begin
      o_err_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // Main sequencer: capture operands, hold them through transmit, latch the result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_WAIT_A;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      case (state)
        ST_WAIT_A: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            state   <= ST_WAIT_OP;
          end else if (timeout_hit) begin
            state <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            state    <= ST_EXEC;
          end else if (timeout_hit) begin
            state <= ST_WAIT_A;
          end
        end
        ST_EXEC: begin
          o_tx_data <= i_alu_result;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            state <= ST_WAIT_A;
          end
        end
        default: begin
          state <= ST_WAIT_A;
        end
      endcase
    end
  end

  // Decoded straight from the state register so both are glitch-free.
  assign o_tx_start = (state == ST_SEND);
  assign o_busy     = (state != ST_WAIT_A);

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Sequences the UART receive/transmit datapath around the ALU. It collects three consecutive received bytes (operand A, operand B, opcode) from the receiver's parallel output and done strobe, then presents them to the combinational ALU. It captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between uart_rx, the ALU and uart_tx in the TP2 top level.

Parameters:
NB_DATA, 8, width of received byte, operands and result
NB_OP, 6, opcode width; taken from i_rx_data[NB_OP-1:0]
NB_TIMEOUT, 20, width of inter-byte timeout counter
TIMEOUT_TICKS, 1000000, clock cycles allowed between bytes (used only with the optional feature)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_DATA  byte from receiver; valid while i_rx_done=1
i_rx_done  in  1  one-cycle strobe: new byte available
i_alu_result  in  NB_DATA  combinational ALU result of o_alu_a/o_alu_b/o_alu_op
i_tx_done  in  1  one-cycle strobe: transmitter finished the frame
o_alu_a  out  NB_DATA  operand A register
o_alu_b  out  NB_DATA  operand B register
o_alu_op  out  NB_OP  opcode register
o_tx_data  out  NB_DATA  result byte to transmitter
o_tx_start  out  1  one-cycle transmit request
o_busy  out  1  high in every state except ST_WAIT_A
o_err_timeout  out  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Reset: state=ST_WAIT_A. o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0. o_tx_start=0, o_busy=0, o_err_timeout=0. Reset mid-operation aborts any transaction; a pending tx_done is ignored.
- States (3-bit encoding): ST_WAIT_A=0, ST_WAIT_B=1, ST_WAIT_OP=2, ST_EXEC=3, ST_SEND=4, ST_WAIT_TX=5. Codes 6 and 7 go to ST_WAIT_A on the next clock.
- ST_WAIT_A: on i_rx_done, o_alu_a<=i_rx_data and go to ST_WAIT_B.
- ST_WAIT_B: on i_rx_done, o_alu_b<=i_rx_data and go to ST_WAIT_OP.
- ST_WAIT_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_OP-1:0] and go to ST_EXEC.
- ST_EXEC: lasts one cycle, giving the ALU one full cycle to settle. At the end of the cycle, o_tx_data<=i_alu_result and go to ST_SEND.
- ST_SEND: o_tx_start=1 (decoded from the state register, glitch-free). Unconditionally go to ST_WAIT_TX. o_tx_start is high for exactly one cycle per transaction.
- ST_WAIT_TX: on i_tx_done, go to ST_WAIT_A.
- Latency: opcode i_rx_done sampled at edge T → ST_EXEC during cycle T..T+1 → o_tx_data valid and o_tx_start=1 during cycle T+1..T+2.
- i_rx_done in ST_EXEC, ST_SEND or ST_WAIT_TX: byte dropped, no register changes.
- i_tx_done outside ST_WAIT_TX: ignored.
- Operand registers hold their values until overwritten. The ALU inputs stay stable while the transmitter sends.
- o_busy = (state != ST_WAIT_A), combinational from the state register.

Optional Feature:
UART_SEQ_TIMEOUT_EN
- Defined:
  - A NB_TIMEOUT-bit counter clears on every state change and on i_rx_done.
  - It increments each cycle in ST_WAIT_B and ST_WAIT_OP.
  - When it reaches TIMEOUT_TICKS-1 with no i_rx_done that cycle: go to ST_WAIT_A, pulse o_err_timeout for one cycle, counter clears.
  - If i_rx_done and timeout coincide, the byte wins.
  - Partial operands are retained but are overwritten by the next transaction.
- Undefined: no counter is instantiated, o_err_timeout is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Package uart_seq_pkg: state localparams (NB_STATE=3, ST_* codes), NB_DATA/NB_OP defaults, opcode constants shared with the ALU (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111).
- One sub-module, uart_seq_timeout: the clearable up-counter with terminal-count output. It is instantiated only under UART_SEQ_TIMEOUT_EN.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 (ADD) with model ALU → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08 with o_tx_start high exactly 1 cycle, 2 cycles after the op strobe.
- Bytes 0x03, 0x05, 0x22 (SUB) → o_tx_data=0xFE. Extra i_rx_done 0xAA during ST_WAIT_TX → dropped, registers unchanged. i_tx_done → o_busy=0.
- Two back-to-back transactions (0xF0, 0x0F, 0x25 OR, then 0xFF, 0x01, 0x20 ADD) → results 0xFF then 0x00 (wrap-around); two o_tx_start pulses, second only after first i_tx_done.
- i_reset asserted in ST_WAIT_OP after two bytes → all outputs 0, state ST_WAIT_A. Following three bytes form a fresh transaction.
- Stray i_tx_done in ST_WAIT_A and in ST_SEND → no state change; o_tx_start count unchanged.
- With UART_SEQ_TIMEOUT_EN, TIMEOUT_TICKS=16: byte 0x11, then silence → o_err_timeout pulses once at the 16th idle cycle and o_busy drops. Without the macro, same stimulus → remains in ST_WAIT_B, o_err_timeout=0.
